// File: rtl/gb_cart_pkg.sv
// Shared cartridge-mapper types, address windows and helpers.
// Used by cart_mbc1 (optional cart RAM via CART_MBC1_RAM_EN).
package gb_cart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR_WAIT
    } state_t;

    // cart_addr[15:14] ROM windows, cart_addr[15:13] RAM window
    localparam logic [1:0] ROM0_WIN = 2'b00;
    localparam logic [1:0] ROMX_WIN = 2'b01;
    localparam logic [2:0] RAM_WIN  = 3'b101;

    // cart_addr[14:13] register windows inside 0000-7FFF
    localparam logic [1:0] WIN_RAMEN  = 2'd0;
    localparam logic [1:0] WIN_BANKLO = 2'd1;
    localparam logic [1:0] WIN_BANKHI = 2'd2;
    localparam logic [1:0] WIN_MODE   = 2'd3;

    localparam logic [3:0] RAM_EN_KEY = 4'hA;

    function automatic logic [7:0] sel_byte(input logic [15:0] w,
                                            input logic odd);
        return odd ? w[7:0] : w[15:8];
    endfunction

endpackage

// File: rtl/cart_mbc1_regs.sv
// MBC1 bank registers and cart-address to external byte-address mapper.
// The ram_en register exists only when CART_MBC1_RAM_EN is defined.
module cart_mbc1_regs
    import gb_cart_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int ROM_BANKS_LOG2 = 5,
    parameter logic [ADDR_W-1:0] RAM_BASE = 22'h200000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_we,
    input  logic [4:0]        reg_data,
    input  logic [15:0]       map_addr,
    output logic [ADDR_W-1:0] byte_addr,
    output logic              is_rom,
    output logic              is_ram
);

    localparam logic [6:0] BANK_MASK = 7'((1 << ROM_BANKS_LOG2) - 1);

    logic [4:0] bank_lo;
    logic [1:0] bank_hi;
    logic       mode;
    logic       ram_en;
    logic [6:0] rom_bank;
    logic [1:0] ram_bank;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_lo <= 5'd1;
            bank_hi <= 2'd0;
            mode    <= 1'b0;
        end else if (reg_we) begin
            unique case (1'b1)
                map_addr[14:13] == WIN_BANKLO:
                    bank_lo <= (reg_data == 5'd0) ? 5'd1 : reg_data;
                map_addr[14:13] == WIN_BANKHI: bank_hi <= reg_data[1:0];
                map_addr[14:13] == WIN_MODE:   mode <= reg_data[0];
                default: ;
            endcase
        end
    end

`ifdef CART_MBC1_RAM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ram_en <= 1'b0;
        else if (reg_we && map_addr[14:13] == WIN_RAMEN)
            ram_en <= (reg_data[3:0] == RAM_EN_KEY);
    end
`else
    assign ram_en = 1'b0;
`endif

    always_comb begin
        rom_bank  = 7'd0;
        ram_bank  = 2'd0;
        byte_addr = '0;
        is_rom    = 1'b0;
        is_ram    = 1'b0;
        if (map_addr[15:14] == ROMX_WIN)
            rom_bank = {bank_hi, bank_lo};
        else if (map_addr[15:14] == ROM0_WIN && mode)
            rom_bank = {bank_hi, 5'd0};
        if (mode)
            ram_bank = bank_hi;
        if (!map_addr[15]) begin
            is_rom    = 1'b1;
            byte_addr = ADDR_W'({rom_bank & BANK_MASK, map_addr[13:0]});
        end else if (map_addr[15:13] == RAM_WIN && ram_en) begin
            is_ram    = 1'b1;
            byte_addr = RAM_BASE + ADDR_W'({ram_bank, map_addr[12:0]});
        end
    end

endmodule

// File: rtl/cart_mbc1.sv
// MBC1 cartridge bridge: bank mapping, one-word read buffer, req/ack port.
// Define CART_MBC1_RAM_EN to build the cart RAM path and WR_WAIT state.
module cart_mbc1
    import gb_cart_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int ROM_BANKS_LOG2 = 5,
    parameter logic [ADDR_W-1:0] RAM_BASE = 22'h200000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       cart_addr,
    input  logic              cart_rd,
    input  logic              cart_wr,
    input  logic [7:0]        cart_di,
    output logic [7:0]        cart_do,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
);

    state_t state, state_nx;

    logic              wr_q, wr_edge, wr_go, we_q;
    logic              pend_v;
    logic [15:0]       pend_addr, wr_addr, map_addr;
    logic [7:0]        pend_data, wr_data;
    logic              buf_v, hit, rd_lsb;
    logic [ADDR_W-2:0] buf_tag, word;
    logic [15:0]       buf_data;
    logic [ADDR_W-1:0] byte_addr;
    logic              is_rom, is_ram;

    assign wr_edge  = cart_wr && !wr_q;
    assign wr_go    = (state == ST_IDLE) && (pend_v || wr_edge);
    assign wr_addr  = pend_v ? pend_addr : cart_addr;
    assign wr_data  = pend_v ? pend_data : cart_di;
    assign map_addr = wr_go ? wr_addr : cart_addr;
    assign word     = byte_addr[ADDR_W-1:1];
    assign hit      = buf_v && (buf_tag == word);

    cart_mbc1_regs #(
        .ADDR_W(ADDR_W),
        .ROM_BANKS_LOG2(ROM_BANKS_LOG2),
        .RAM_BASE(RAM_BASE)
    ) u_regs (
        .clk(clk),
        .reset_n(reset_n),
        .reg_we(wr_go && is_rom),
        .reg_data(wr_data[4:0]),
        .map_addr(map_addr),
        .byte_addr(byte_addr),
        .is_rom(is_rom),
        .is_ram(is_ram)
    );

`ifdef CART_MBC1_RAM_EN
    assign mem_we = we_q;
`else
    logic unused_ram;
    assign mem_we = 1'b0;
    assign unused_ram = we_q | (|wr_data[7:5]);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (wr_go) begin
`ifdef CART_MBC1_RAM_EN
                    if (is_ram) state_nx = ST_WR_WAIT;
`endif
                end else if (cart_rd && (is_rom || is_ram) && !hit) begin
                    state_nx = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: if (mem_ack) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cart_do   <= 8'hFF;
            mem_req   <= 1'b0;
            we_q      <= 1'b0;
            mem_be    <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= 16'h0000;
            wr_q      <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= 16'h0000;
            pend_data <= 8'h00;
            buf_v     <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= 16'h0000;
            rd_lsb    <= 1'b0;
        end else begin
            wr_q <= cart_wr;
            // edges seen while busy wait in a one-deep slot
            if (wr_edge && (state != ST_IDLE || pend_v)) begin
                pend_v    <= 1'b1;
                pend_addr <= cart_addr;
                pend_data <= cart_di;
            end else if (wr_go) begin
                pend_v <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (wr_go) begin
`ifdef CART_MBC1_RAM_EN
                        if (is_ram) begin
                            mem_req   <= 1'b1;
                            we_q      <= 1'b1;
                            mem_be    <= byte_addr[0] ? 2'b01 : 2'b10;
                            mem_addr  <= {word, 1'b0};
                            mem_wdata <= {wr_data, wr_data};
                            if (hit) buf_v <= 1'b0;
                        end
`endif
                    end else if (cart_rd) begin
                        if (!(is_rom || is_ram)) begin
                            cart_do <= 8'hFF;
                        end else if (hit) begin
                            cart_do <= sel_byte(buf_data, byte_addr[0]);
                        end else begin
                            mem_req  <= 1'b1;
                            we_q     <= 1'b0;
                            mem_be   <= 2'b11;
                            mem_addr <= {word, 1'b0};
                            rd_lsb   <= byte_addr[0];
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        buf_v    <= 1'b1;
                        buf_tag  <= mem_addr[ADDR_W-1:1];
                        buf_data <= mem_rdata;
                        cart_do  <= sel_byte(mem_rdata, rd_lsb);
                    end
                end
                ST_WR_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        we_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_mbc1.sv
// Directed self-checking bench for cart_mbc1 (ROM_BANKS_LOG2 = 7).
// Covers the RAM path when CART_MBC1_RAM_EN is defined.
module tb_cart_mbc1;

    logic        clk;
    logic        reset_n;
    logic [15:0] cart_addr;
    logic        cart_rd;
    logic        cart_wr;
    logic [7:0]  cart_di;
    logic [7:0]  cart_do;
    logic [21:0] mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int total = 0;
    int passed = 0;

    cart_mbc1 #(
        .ADDR_W(22),
        .ROM_BANKS_LOG2(7),
        .RAM_BASE(22'h200000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cart_addr(cart_addr),
        .cart_rd(cart_rd),
        .cart_wr(cart_wr),
        .cart_di(cart_di),
        .cart_do(cart_do),
        .mem_addr(mem_addr),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [15:0] a,
                      input logic fetch, input logic [21:0] ea,
                      input logic [15:0] rdat, input logic [7:0] ed);
        cart_addr = a;
        cart_rd = 1'b1;
        cyc();
        if (fetch) begin
            chk({tag, ":req"}, 32'(mem_req), 32'd1);
            chk({tag, ":addr"}, 32'(mem_addr), 32'(ea));
            chk({tag, ":we"}, 32'(mem_we), 32'd0);
            mem_ack = 1'b1;
            mem_rdata = rdat;
            cyc();
            mem_ack = 1'b0;
            chk({tag, ":drop"}, 32'(mem_req), 32'd0);
        end else begin
            chk({tag, ":noreq"}, 32'(mem_req), 32'd0);
        end
        chk({tag, ":do"}, 32'(cart_do), 32'(ed));
        cart_rd = 1'b0;
        cyc();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cart_addr = a;
        cart_di = d;
        cart_wr = 1'b1;
        cyc();
        cyc();
        cart_wr = 1'b0;
        cyc();
    endtask

    initial begin
        reset_n = 1'b0;
        cart_addr = 16'h0000;
        cart_rd = 1'b0;
        cart_wr = 1'b0;
        cart_di = 8'h00;
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        cyc();
        cyc();
        chk("rst:do", 32'(cart_do), 32'hFF);
        chk("rst:req", 32'(mem_req), 32'd0);
        chk("rst:we", 32'(mem_we), 32'd0);
        chk("rst:be", 32'(mem_be), 32'd0);
        chk("rst:addr", 32'(mem_addr), 32'd0);
        reset_n = 1'b1;
        cyc();

        rd("rom0_miss", 16'h0100, 1'b1, 22'h000100, 16'h00C3, 8'h00);
        rd("rom0_hit", 16'h0101, 1'b0, 22'h0, 16'h0, 8'hC3);

        wr(16'h2000, 8'h00);
        rd("bank0_as1", 16'h4000, 1'b1, 22'h004000, 16'h1234, 8'h12);

        cart_addr = 16'h4100;
        cart_rd = 1'b1;
        cyc();
        chk("q:req", 32'(mem_req), 32'd1);
        chk("q:addr", 32'(mem_addr), 32'h004100);
        cart_rd = 1'b0;
        cart_addr = 16'h2000;
        cart_di = 8'h02;
        cart_wr = 1'b1;
        cyc();
        chk("q:hold_req", 32'(mem_req), 32'd1);
        chk("q:hold_addr", 32'(mem_addr), 32'h004100);
        mem_ack = 1'b1;
        mem_rdata = 16'h9A9B;
        cyc();
        mem_ack = 1'b0;
        chk("q:do", 32'(cart_do), 32'h9A);
        chk("q:drop", 32'(mem_req), 32'd0);
        cart_wr = 1'b0;
        cyc();
        rd("q:bank2", 16'h4000, 1'b1, 22'h008000, 16'h4444, 8'h44);

        wr(16'h2000, 8'h1F);
        wr(16'h4000, 8'h03);
        rd("bank7f", 16'h7FFF, 1'b1, 22'h1FFFFE, 16'hABCD, 8'hCD);
        wr(16'h6000, 8'h01);
        rd("mode1_rom0", 16'h0000, 1'b1, 22'h180000, 16'h5566, 8'h55);
        wr(16'h6000, 8'h00);

        rd("ramoff", 16'hA000, 1'b0, 22'h0, 16'h0, 8'hFF);
        rd("unmapped", 16'hC000, 1'b0, 22'h0, 16'h0, 8'hFF);

`ifdef CART_MBC1_RAM_EN
        wr(16'h0000, 8'h0A);
        rd("ram_fill", 16'hA001, 1'b1, 22'h200000, 16'h7788, 8'h88);
        rd("ram_hit", 16'hA001, 1'b0, 22'h0, 16'h0, 8'h88);
        cart_addr = 16'hA001;
        cart_di = 8'h5A;
        cart_wr = 1'b1;
        cyc();
        chk("ramwr:req", 32'(mem_req), 32'd1);
        chk("ramwr:we", 32'(mem_we), 32'd1);
        chk("ramwr:be", 32'(mem_be), 32'd1);
        chk("ramwr:addr", 32'(mem_addr), 32'h200000);
        chk("ramwr:wdata", 32'(mem_wdata), 32'h5A5A);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        cart_wr = 1'b0;
        chk("ramwr:drop", 32'(mem_req), 32'd0);
        cyc();
        rd("ram_refetch", 16'hA001, 1'b1, 22'h200000, 16'h775A, 8'h5A);
`else
        wr(16'h0000, 8'h0A);
        cart_addr = 16'hA001;
        cart_di = 8'h5A;
        cart_wr = 1'b1;
        cyc();
        chk("noram:req", 32'(mem_req), 32'd0);
        chk("noram:we", 32'(mem_we), 32'd0);
        cart_wr = 1'b0;
        cyc();
        rd("noram_rd", 16'hA001, 1'b0, 22'h0, 16'h0, 8'hFF);
`endif

        cart_addr = 16'h0200;
        cart_rd = 1'b1;
        cyc();
        chk("rstmid:req", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid:drop", 32'(mem_req), 32'd0);
        cart_rd = 1'b0;
        cyc();
        reset_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        cyc();
        mem_ack = 1'b0;
        chk("rstmid:late_do", 32'(cart_do), 32'hFF);
        chk("rstmid:late_req", 32'(mem_req), 32'd0);
        rd("rstmid:refetch", 16'h0000, 1'b1, 22'h000000, 16'hBEEF, 8'hBE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
